// File: rtl/pc_fetch_seq.sv
// Program counter and instruction-fetch sequencer: req/ack fetch to memory, valid/taken to decoder.
// Define CALL_STACK_EN to build the STACK_D-entry return stack for Call/Ret.
module pc_fetch_seq #(
  parameter int            AW        = 8,
  parameter int            IW        = 16,
  parameter logic [AW-1:0] RESET_VEC = '0,
  parameter int            STACK_D   = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  output logic          MemReq,
  output logic [AW-1:0] MemAddr,
  input  logic          MemAck,
  input  logic [IW-1:0] MemData,
  output logic          IrValid,
  output logic [IW-1:0] Ir,
  output logic [AW-1:0] Pc,
  input  logic          IrTaken,
  input  logic          Jump,
  input  logic [AW-1:0] JumpAddr,
  input  logic          Call,
  input  logic          Ret,
  output logic          StackErr
);

  // state | meaning
  // IDLE  | out of reset; first fetch issued next cycle
  // REQ   | fetch outstanding, MemReq held high until MemAck
  // HOLD  | Ir/Pc valid, waiting for the decoder
  typedef enum logic [1:0] {IDLE, REQ, HOLD} stateT;

  stateT         state, stateD;
  logic [AW-1:0] memAddrQ, memAddrD;
  logic [IW-1:0] irQ, irD;
  logic [AW-1:0] pcQ, pcD;
  logic          irValidQ, irValidD;
  logic          pendQ, pendD;
  logic [AW-1:0] tgtQ, tgtD;

  logic          redir;
  logic [AW-1:0] redirAddr;

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(STACK_D + 1);
  localparam int IXW = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  logic [AW-1:0]  stack [STACK_D];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] spDec;
  logic           doPush, doPop, errSet, stackErrQ;

  assign spDec = sp - 1'b1;

  // Ret beats Call beats Jump; an empty pop still redirects, to the reset vector
  always_comb begin
    redir     = 1'b0;
    redirAddr = JumpAddr;
    doPush    = 1'b0;
    doPop     = 1'b0;
    errSet    = 1'b0;
    if (Ret) begin
      redir = 1'b1;
      if (sp == '0) begin
        redirAddr = RESET_VEC;
        errSet    = 1'b1;
      end else begin
        redirAddr = stack[spDec[IXW-1:0]];
        doPop     = 1'b1;
      end
    end else if (Call) begin
      redir = 1'b1;
      if (sp == SPW'(STACK_D)) errSet = 1'b1;
      else                     doPush = 1'b1;
    end else if (Jump) begin
      redir = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sp        <= '0;
      stackErrQ <= 1'b0;
    end else begin
      if (doPush)     sp <= sp + 1'b1;
      else if (doPop) sp <= spDec;
      if (errSet) stackErrQ <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (doPush) stack[sp[IXW-1:0]] <= pcQ + 1'b1;
  end

  assign StackErr = stackErrQ;
`else
  localparam int unusedStackDepth = STACK_D;
  logic unusedRet;

  assign unusedRet = Ret;
  assign redir     = Jump | Call;
  assign redirAddr = JumpAddr;
  assign StackErr  = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      memAddrQ <= RESET_VEC;
      irQ      <= '0;
      pcQ      <= RESET_VEC;
      irValidQ <= 1'b0;
      pendQ    <= 1'b0;
      tgtQ     <= RESET_VEC;
    end else begin
      state    <= stateD;
      memAddrQ <= memAddrD;
      irQ      <= irD;
      pcQ      <= pcD;
      irValidQ <= irValidD;
      pendQ    <= pendD;
      tgtQ     <= tgtD;
    end
  end

  always_comb begin
    stateD   = state;
    memAddrD = memAddrQ;
    irD      = irQ;
    pcD      = pcQ;
    irValidD = irValidQ;
    pendD    = pendQ;
    tgtD     = tgtQ;
    unique case (state)
      IDLE: begin
        if (redir) memAddrD = redirAddr;
        stateD = REQ;
      end
      REQ: begin
        // MemAddr must stay put while the request is open, so a redirect is parked
        if (MemAck) begin
          if (redir || pendQ) begin
            memAddrD = redir ? redirAddr : tgtQ;
            pendD    = 1'b0;
          end else begin
            irD      = MemData;
            pcD      = memAddrQ;
            irValidD = 1'b1;
            stateD   = HOLD;
          end
        end else if (redir) begin
          tgtD  = redirAddr;
          pendD = 1'b1;
        end
      end
      HOLD: begin
        if (redir) begin
          irValidD = 1'b0;
          memAddrD = redirAddr;
          stateD   = REQ;
        end else if (IrTaken) begin
          irValidD = 1'b0;
          memAddrD = pcQ + 1'b1;
          stateD   = REQ;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign MemReq  = (state == REQ);
  assign MemAddr = memAddrQ;
  assign IrValid = irValidQ;
  assign Ir      = irQ;
  assign Pc      = pcQ;

endmodule
